nms_suppress: RTL and testbench



---
 rtl/nms_pkg.sv | 27 ++
 rtl/nms_suppress_if.sv | 15 +
 rtl/nms_line_buffer.sv | 37 +++
 rtl/nms_suppress.sv | 174 +++++++++++++++++
 tb/tb_nms_suppress.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/nms_pkg.sv
// nms_pkg: shared constants and types for the non-maximum suppression block.
//   Field slices of the packed {direct[1:0], grad[23:0]} input word,
//   quantised gradient direction codes and the controller state encoding.
package nms_pkg;

    localparam int MAG_MSB = 23;
    localparam int DIR_LSB = 24;
    localparam int GS_W    = DIR_LSB + 2;

    // Quantised gradient direction as produced by the gradient filter
    localparam logic [1:0] DIR_N  = 2'b00;
    localparam logic [1:0] DIR_E  = 2'b01;
    localparam logic [1:0] DIR_NW = 2'b10;
    localparam logic [1:0] DIR_NE = 2'b11;

    // Controller states
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef struct packed {
        logic [1:0]       dir;
        logic [MAG_MSB:0] mag;
    } gs_t;

endpackage

// File: rtl/nms_suppress_if.sv
// nms_suppress_if: pixel stream in / suppressed magnitude stream out.
//   data_en, grad_square : input beat valid and packed {dir, magnitude}
//   nms_en, nms_data     : output beat valid and suppressed magnitude
//   master = stream producer / result consumer, slave = the NMS block.
interface nms_suppress_if;
    import nms_pkg::*;

    logic               data_en;
    logic [GS_W-1:0]    grad_square;
    logic               nms_en;
    logic [MAG_MSB:0]   nms_data;

    modport master (output data_en, grad_square, input  nms_en, nms_data);
    modport slave  (input  data_en, grad_square, output nms_en, nms_data);
endinterface

// File: rtl/nms_line_buffer.sv
// nms_line_buffer: one raster line of delay, WIDTH entries of DW bits.
//   clk, rst_n : clock, async active-low reset (column counter only)
//   clr        : synchronous return of the column counter to 0
//   we         : beat strobe; writes wd at the current column and advances
//   wd / rd    : write data / read data of the current column. The read is
//                combinational, so a same-cycle write sees the old entry.
module nms_line_buffer #(
    parameter int WIDTH = 512,
    parameter int DW    = 26
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          we,
    input  logic [DW-1:0] wd,
    output logic [DW-1:0] rd
);
    localparam int CW = $clog2(WIDTH);

    logic [DW-1:0] mem [WIDTH];
    logic [CW-1:0] col;

    assign rd = mem[col];

    // Storage needs no reset; stale entries only ever reach border pixels.
    always_ff @(posedge clk)
        if (we) mem[col] <= wd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                   col <= '0;
        else if (clr)                 col <= '0;
        else if (we) begin
            if (col == CW'(WIDTH - 1)) col <= '0;
            else                       col <= col + CW'(1);
        end
    end
endmodule

// File: rtl/nms_suppress.sv
// nms_suppress: Canny non-maximum suppression over a 3x3 magnitude window.
//   clk, rst_n    : clock, async active-low reset
//   start         : run enable; low returns to IDLE and drops in-flight data
//   bus (slave)   : data_en/grad_square in, nms_en/nms_data out
//   frame_done    : one-cycle pulse the cycle after the last output of a frame
//   busy          : high in RUN or FLUSH
//   err_overflow  : sticky, set when a beat arrives during FLUSH
// Optional: define NMS_LOW_THRESH_EN to zero kept magnitudes below LOW_THRESH.
// Pipeline: beat cycle -> window shift (stage 1) -> registered compare (stage 2).
module nms_suppress
    import nms_pkg::*;
#(
    parameter int                    WIDTH      = 512,
    parameter int                    DEPTH      = 638,
    parameter int                    DATA_WIDTH = 24,
    parameter logic [DATA_WIDTH-1:0] LOW_THRESH = 24'd0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    nms_suppress_if.slave bus,
    output logic          frame_done,
    output logic          busy,
    output logic          err_overflow
);
    localparam int PIX    = WIDTH * DEPTH;
    localparam int CW     = $clog2(WIDTH);
    localparam int RW     = $clog2(DEPTH + 2);
    localparam int NW     = $clog2(PIX + 1);
    localparam int FW     = $clog2(WIDTH + 1);
    localparam int STAGES = 2;

    logic [1:0]            state;
    logic [NW-1:0]         in_cnt;
    logic [FW-1:0]         fl_cnt;
    logic [CW-1:0]         bc;      // column of the incoming beat
    logic [RW-1:0]         br;      // row of the incoming beat
    logic [STAGES:1]       vld_pipe;
    logic                  s1_border;
    logic [DATA_WIDTH-1:0] nms_q;
    gs_t [2:0][2:0]        win;     // [row: 0=up,2=down][col: 0=left,2=right]
    gs_t                   beat_d, up1, up2;

    logic                  acc, inj, beat_v, lb_clr, cv, border, keep;
    logic [CW-1:0]         cc;
    logic [RW-1:0]         cr;
    logic [DATA_WIDTH-1:0] mag_c, mag_a, mag_b, res;

    // Real beats are taken only in IDLE/RUN; FLUSH injects zeros that push
    // the last WIDTH+1 centres through the window.
    assign acc    = start && bus.data_en && (state == ST_IDLE || state == ST_RUN);
    assign inj    = start && (state == ST_FLUSH);
    assign beat_v = acc || inj;
    assign beat_d = inj ? '0 : gs_t'(bus.grad_square);
    assign lb_clr = !start || (state == ST_DONE);
    assign busy   = (state == ST_RUN) || (state == ST_FLUSH);

    nms_line_buffer #(.WIDTH(WIDTH), .DW(GS_W)) u_lb0 (
        .clk(clk), .rst_n(rst_n), .clr(lb_clr), .we(beat_v), .wd(beat_d), .rd(up1)
    );
    nms_line_buffer #(.WIDTH(WIDTH), .DW(GS_W)) u_lb1 (
        .clk(clk), .rst_n(rst_n), .clr(lb_clr), .we(beat_v), .wd(up1), .rd(up2)
    );

    // Beat j resolves centre j-WIDTH-1: one row up, one column left.
    always_comb begin
        if (bc == '0) begin
            cc = CW'(WIDTH - 1);
            cr = br - RW'(2);
        end else begin
            cc = bc - CW'(1);
            cr = br - RW'(1);
        end
        cv     = beat_v && ((br >= RW'(2)) || (br == RW'(1) && bc != '0));
        border = (cr == '0) || (cr == RW'(DEPTH - 1)) || (cc == '0) || (cc == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk)
        if (beat_v)
            for (int r = 0; r < 3; r++) begin
                win[r][0] <= win[r][1];
                win[r][1] <= win[r][2];
                win[r][2] <= (r == 0) ? up2 : (r == 1) ? up1 : beat_d;
            end

    // a = earlier neighbour in raster order (strict), b = later (ties keep)
    always_comb begin
        mag_c = win[1][1].mag;
        case (win[1][1].dir)
            DIR_E:   begin mag_a = win[1][0].mag; mag_b = win[1][2].mag; end
            DIR_N:   begin mag_a = win[0][1].mag; mag_b = win[2][1].mag; end
            DIR_NE:  begin mag_a = win[0][2].mag; mag_b = win[2][0].mag; end
            default: begin mag_a = win[0][0].mag; mag_b = win[2][2].mag; end
        endcase
        keep = (mag_c > mag_a) && (mag_c >= mag_b);
`ifdef NMS_LOW_THRESH_EN
        keep = keep && (mag_c >= LOW_THRESH);
`endif
        res = (keep && !s1_border) ? mag_c : '0;
    end

`ifndef NMS_LOW_THRESH_EN
    logic [DATA_WIDTH-1:0] unused_thresh;
    assign unused_thresh = LOW_THRESH;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            in_cnt       <= '0;
            fl_cnt       <= '0;
            bc           <= '0;
            br           <= '0;
            vld_pipe     <= '0;
            s1_border    <= 1'b0;
            nms_q        <= '0;
            frame_done   <= 1'b0;
            err_overflow <= 1'b0;
        end else if (!start) begin
            state      <= ST_IDLE;
            in_cnt     <= '0;
            fl_cnt     <= '0;
            bc         <= '0;
            br         <= '0;
            vld_pipe   <= '0;
            nms_q      <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            vld_pipe   <= {vld_pipe[1], cv};
            s1_border  <= border;
            nms_q      <= vld_pipe[1] ? res : '0;
            if (beat_v) begin
                if (bc == CW'(WIDTH - 1)) begin
                    bc <= '0;
                    br <= br + RW'(1);
                end else begin
                    bc <= bc + CW'(1);
                end
            end
            case (state)
                ST_IDLE:
                    if (acc) begin
                        state  <= ST_RUN;
                        in_cnt <= NW'(1);
                    end
                ST_RUN:
                    if (acc) begin
                        in_cnt <= in_cnt + NW'(1);
                        if (in_cnt == NW'(PIX - 1)) state <= ST_FLUSH;
                    end
                ST_FLUSH: begin
                    if (bus.data_en) err_overflow <= 1'b1;
                    if (fl_cnt == FW'(WIDTH)) state <= ST_DONE;
                    else                      fl_cnt <= fl_cnt + FW'(1);
                end
                default: begin
                    // Wait for the last centre to leave stage 1, then pulse.
                    bc     <= '0;
                    br     <= '0;
                    in_cnt <= '0;
                    fl_cnt <= '0;
                    if (!vld_pipe[1]) begin
                        frame_done <= 1'b1;
                        state      <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.nms_en   = vld_pipe[STAGES];
    assign bus.nms_data = nms_q;
endmodule

// File: tb/tb_nms_suppress.sv
// tb_nms_suppress: directed + randomized frames on an 8x6 image, checked
// against a per-pixel reference of the suppression rules and the
// beat-to-output timing.
module tb_nms_suppress;
    import nms_pkg::*;

    localparam int W = 8;
    localparam int D = 6;
    localparam int N = W * D;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic frame_done, busy, err_overflow;

    nms_suppress_if bus ();

    nms_suppress #(.WIDTH(W), .DEPTH(D), .DATA_WIDTH(24), .LOW_THRESH(24'd300)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .bus(bus.slave),
        .frame_done(frame_done), .busy(busy), .err_overflow(err_overflow)
    );

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [25:0] img [N];
    int bcyc [N];
    int out_v [$];
    int out_c [$];
    int fd_cnt = 0;
    int fd_cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;

    always @(negedge clk) begin
        if (bus.nms_en) begin
            out_v.push_back(int'(bus.nms_data));
            out_c.push_back(cyc);
        end
        if (frame_done) begin
            fd_cnt++;
            fd_cyc = cyc;
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int mag(input int k);
        return int'(img[k][23:0]);
    endfunction

    // Reference: keep centre iff > earlier neighbour and >= later one.
    function automatic int ref_px(input int k);
        int r, c, m, a, b;
        r = k / W;
        c = k % W;
        if (r == 0 || r == D - 1 || c == 0 || c == W - 1) return 0;
        m = mag(k);
        case (img[k][25:24])
            DIR_E:   begin a = mag(k - 1);     b = mag(k + 1);     end
            DIR_N:   begin a = mag(k - W);     b = mag(k + W);     end
            DIR_NE:  begin a = mag(k - W + 1); b = mag(k + W - 1); end
            default: begin a = mag(k - W - 1); b = mag(k + W + 1); end
        endcase
        if (!(m > a && m >= b)) return 0;
`ifdef NMS_LOW_THRESH_EN
        if (m < 300) return 0;
`endif
        return m;
    endfunction

    task automatic fill(input logic [1:0] d, input int m);
        for (int k = 0; k < N; k++) img[k] = {d, 24'(m)};
    endtask

    task automatic put(input int r, input int c, input logic [1:0] d, input int m);
        img[r * W + c] = {d, 24'(m)};
    endtask

    task automatic fill_rand(input int maxm);
        for (int k = 0; k < N; k++) img[k] = {2'($urandom), 24'($urandom_range(0, maxm))};
    endtask

    task automatic run_frame(input string tag, input int gapmax, input bit ovf);
        int fd0, bt;
        fd0 = fd_cnt;
        out_v.delete();
        out_c.delete();
        for (int j = 0; j < N; j++) begin
            repeat ($urandom_range(0, gapmax)) begin
                bus.data_en = 1'b0;
                step();
            end
            bus.data_en     = 1'b1;
            bus.grad_square = img[j];
            bcyc[j]         = cyc;
            step();
            if (j == W) chk({tag, " busy_run"}, int'(busy), 1);
        end
        bus.data_en = 1'b0;
        if (ovf)
            repeat (3) begin
                bus.data_en     = 1'b1;
                bus.grad_square = 26'($urandom);
                step();
            end
        bus.data_en = 1'b0;
        for (int t = 0; t < 300 && fd_cnt == fd0; t++) step();
        repeat (3) step();
        chk({tag, " frame_done_cnt"}, fd_cnt - fd0, 1);
        chk({tag, " busy_end"}, int'(busy), 0);
        chk({tag, " out_count"}, out_v.size(), N);
        for (int k = 0; k < N; k++) begin
            bt = k + W + 1;
            bt = (bt < N) ? bcyc[bt] : bcyc[N - 1] + (bt - (N - 1));
            chk($sformatf("%s px%0d", tag, k), (k < out_v.size()) ? out_v[k] : -1, ref_px(k));
            chk($sformatf("%s lat%0d", tag, k), (k < out_c.size()) ? out_c[k] : -1, bt + 2);
        end
        chk({tag, " frame_done_cyc"}, fd_cyc, (out_c.size() == N) ? out_c[N - 1] + 1 : -1);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, " nms_en"}, int'(bus.nms_en), 0);
        chk({tag, " nms_data"}, int'(bus.nms_data), 0);
        chk({tag, " frame_done"}, int'(frame_done), 0);
        chk({tag, " busy"}, int'(busy), 0);
        chk({tag, " err_overflow"}, int'(err_overflow), 0);
    endtask

    task automatic partial_frame(input int beats);
        for (int j = 0; j < beats; j++) begin
            bus.data_en     = 1'b1;
            bus.grad_square = img[j];
            step();
        end
        bus.data_en = 1'b0;
    endtask

    initial begin
        bus.data_en     = 1'b0;
        bus.grad_square = '0;
        repeat (2) step();
        chk_idle_outputs("reset");
        rst_n = 1'b1;
        step();
        start = 1'b1;
        step();

        // Flat field: strict compare on the earlier neighbour kills everything
        fill(DIR_E, 100);
        run_frame("const_e", 2, 1'b0);
        chk("const_e err", int'(err_overflow), 0);

        // Isolated horizontal peak
        fill(DIR_E, 0);
        put(2, 2, DIR_E, 400);
        put(2, 3, DIR_E, 500);
        put(2, 4, DIR_E, 400);
        run_frame("peak_e", 0, 1'b0);
        chk("peak_e centre", (out_v.size() == N) ? out_v[2 * W + 3] : -1, 500);

        // Vertical direction, larger neighbours above and below
        fill(DIR_E, 0);
        put(2, 3, DIR_N, 500);
        put(1, 3, DIR_E, 600);
        put(3, 3, DIR_E, 600);
        run_frame("peak_n", 1, 1'b0);

        // NE diagonal: larger up-right suppresses; tie on down-left keeps
        fill(DIR_E, 0);
        put(2, 3, DIR_NE, 500);
        put(1, 4, DIR_E, 600);
        run_frame("ne_sup", 1, 1'b0);
        put(1, 4, DIR_E, 499);
        put(3, 2, DIR_E, 500);
        run_frame("ne_tie", 1, 1'b0);
        chk("ne_tie centre", (out_v.size() == N) ? out_v[2 * W + 3] : -1, 500);

        // Beats during FLUSH: dropped, sticky error, next frame unaffected
        fill_rand(1000);
        run_frame("ovf", 1, 1'b1);
        chk("ovf err", int'(err_overflow), 1);
        fill_rand(1000);
        run_frame("after_ovf", 3, 1'b0);
        chk("after_ovf err_sticky", int'(err_overflow), 1);

        // start dropped mid-frame
        fill_rand(1000);
        partial_frame(20);
        start = 1'b0;
        step();
        out_v.delete();
        chk("stop busy", int'(busy), 0);
        bus.data_en = 1'b1;
        repeat (10) step();
        bus.data_en = 1'b0;
        chk("stop no_out", out_v.size(), 0);
        chk("stop busy_hold", int'(busy), 0);
        start = 1'b1;
        step();
        fill_rand(1000);
        run_frame("restart", 1, 1'b0);

        // Asynchronous reset mid-frame
        fill_rand(1000);
        partial_frame(20);
        #5;
        rst_n = 1'b0;
        #1;
        chk_idle_outputs("async_rst");
        step();
        rst_n = 1'b1;
        step();
        fill_rand(1000);
        run_frame("post_rst", 1, 1'b0);

        // Two isolated E peaks straddling the optional floor of 300
        fill(DIR_E, 0);
        put(2, 2, DIR_E, 250);
        put(3, 5, DIR_E, 350);
        run_frame("thresh", 1, 1'b0);
`ifdef NMS_LOW_THRESH_EN
        chk("thresh 250", (out_v.size() == N) ? out_v[2 * W + 2] : -1, 0);
`else
        chk("thresh 250", (out_v.size() == N) ? out_v[2 * W + 2] : -1, 250);
`endif
        chk("thresh 350", (out_v.size() == N) ? out_v[3 * W + 5] : -1, 350);

        // Small magnitudes to exercise ties in every direction
        fill_rand(3);
        run_frame("rand_ties", 2, 1'b0);
        fill_rand(5);
        run_frame("rand_ties2", 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
